// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues regfile operands to a 2-cycle registered ALU and writes results back
module alu_issue_ctrl #(
  parameter int DW = 5,
  parameter int NREG = 8,
  parameter logic [3:0] OP_LDI = 4'b1111
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [3:0]               cmd_op_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rd_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rs1_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rs2_i,
  input  logic [DW-1:0]            cmd_imm_i,
  output logic [DW-1:0]            alu_a_o,
  output logic [DW-1:0]            alu_b_o,
  output logic [3:0]               alu_op_o,
  input  logic [DW-1:0]            alu_data_i,
  input  logic                     alu_carry_i,
  output logic                     res_valid_o,
  output logic [$clog2(NREG)-1:0]  res_rd_o,
  output logic [DW-1:0]            res_data_o,
  output logic                     res_carry_o,
  input  logic [$clog2(NREG)-1:0]  dbg_addr_i,
  output logic [DW-1:0]            dbg_data_o
);
  typedef enum logic [1:0] {IDLE, HOLD, EXEC, WB} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [$clog2(NREG)-1:0] rd_q;
  logic [DW-1:0] a_q, b_q, wb_data;
  logic [DW-1:0] rf [NREG];
  logic acc, ldi, drive, wb_carry;
  assign acc = cmd_valid_i && cmd_ready_o;
  assign ldi = op_q == OP_LDI;
  assign wb_data = ldi ? a_q : alu_data_i;
  assign wb_carry = !ldi && alu_carry_i;
  assign dbg_data_o = rf[dbg_addr_i];
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (acc ? (cmd_op_i == OP_LDI ? WB : HOLD) : IDLE) :
              state == HOLD ? EXEC :
              state == EXEC ? WB : IDLE;
  end
  always_comb begin
    drive = state == HOLD || state == EXEC;
    cmd_ready_o = state == IDLE && !rst_i;
    alu_a_o = drive ? a_q : '0;
    alu_b_o = drive ? b_q : '0;
    alu_op_o = drive ? op_q : 4'b0000;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= '0;
      rd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_valid_o <= 1'b0;
      res_rd_o <= '0;
      res_data_o <= '0;
      res_carry_o <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      res_valid_o <= state == WB;
      if (acc) begin
        op_q <= cmd_op_i;
        rd_q <= cmd_rd_i;
        a_q <= cmd_op_i == OP_LDI ? cmd_imm_i : rf[cmd_rs1_i];
        b_q <= rf[cmd_rs2_i];
      end
      if (state == WB) begin
        rf[rd_q] <= wb_data;
        res_rd_o <= rd_q;
        res_data_o <= wb_data;
        res_carry_o <= wb_carry;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector bench with a registered 5-bit ALU model
module tb_alu_issue_ctrl;
  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [4:0] imm, data;
    logic carry;
  } vec_t;
  localparam int N = 10;
  localparam logic [3:0] LDI = 4'b1111, ADD = 4'b0001, SUB = 4'b0010;
  logic clk_i = 0, rst_i = 1, cmd_valid_i = 0;
  logic [3:0] cmd_op_i = 0;
  logic [2:0] cmd_rd_i = 0, cmd_rs1_i = 0, cmd_rs2_i = 0, dbg_addr_i = 0;
  logic [4:0] cmd_imm_i = 0;
  logic cmd_ready_o, res_valid_o, res_carry_o, alu_carry_i;
  logic [4:0] alu_a_o, alu_b_o, alu_data_i, res_data_o, dbg_data_o;
  logic [3:0] alu_op_o;
  logic [2:0] res_rd_o;
  int errs = 0, checks = 0, n_acc = 0, n_res = 0;
  vec_t tv [N];
  logic [4:0] mrf [8];
  alu_issue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .cmd_imm_i(cmd_imm_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_data_i(alu_data_i), .alu_carry_i(alu_carry_i), .res_valid_o(res_valid_o),
    .res_rd_o(res_rd_o), .res_data_o(res_data_o), .res_carry_o(res_carry_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) begin
    case (alu_op_o)
      ADD: {alu_carry_i, alu_data_i} <= {1'b0, alu_a_o} + {1'b0, alu_b_o};
      SUB: {alu_carry_i, alu_data_i} <= {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 6'd1;
      default: {alu_carry_i, alu_data_i} <= {1'b0, alu_a_o ^ alu_b_o};
    endcase
  end
  always @(posedge clk_i) begin
    if (cmd_valid_i && cmd_ready_o) n_acc++;
    if (res_valid_o) n_res++;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_regs_zero(input string nm);
    for (int r = 0; r < 8; r++) begin
      dbg_addr_i = 3'(r);
      #1 chk(nm, dbg_data_o, 0);
    end
  endtask
  initial begin
    vec_t v;
    int lat, wb_lat;
    logic [4:0] ea, eb;
    tv[0] = '{LDI, 3'd1, 3'd0, 3'd0, 5'd5, 5'd5, 1'b0};
    tv[1] = '{LDI, 3'd2, 3'd0, 3'd0, 5'd3, 5'd3, 1'b0};
    tv[2] = '{ADD, 3'd3, 3'd1, 3'd2, 5'd0, 5'd8, 1'b0};
    tv[3] = '{SUB, 3'd4, 3'd2, 3'd1, 5'd0, 5'd30, 1'b0};
    tv[4] = '{SUB, 3'd5, 3'd1, 3'd2, 5'd0, 5'd2, 1'b1};
    tv[5] = '{LDI, 3'd6, 3'd0, 3'd0, 5'd20, 5'd20, 1'b0};
    tv[6] = '{ADD, 3'd6, 3'd6, 3'd6, 5'd0, 5'd8, 1'b1};
    tv[7] = '{ADD, 3'd7, 3'd6, 3'd0, 5'd0, 5'd8, 1'b0};
    tv[8] = '{4'b1011, 3'd0, 3'd1, 3'd2, 5'd0, 5'd6, 1'b0};
    tv[9] = '{4'b0000, 3'd7, 3'd4, 3'd5, 5'd0, 5'd28, 1'b0};
    for (int r = 0; r < 8; r++) mrf[r] = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_ready", cmd_ready_o, 0);
    chk("reset_res_valid", res_valid_o, 0);
    chk("reset_alu_op", alu_op_o, 0);
    chk("reset_alu_a", alu_a_o, 0);
    chk_regs_zero("reset_regfile");
    rst_i = 0;
    @(negedge clk_i);
    chk("ready_after_reset", cmd_ready_o, 1);
    cmd_valid_i = 1;
    for (int i = 0; i < N; i++) begin
      v = tv[i];
      cmd_op_i = v.op;
      cmd_rd_i = v.rd;
      cmd_rs1_i = v.rs1;
      cmd_rs2_i = v.rs2;
      cmd_imm_i = v.imm;
      dbg_addr_i = v.rd;
      ea = mrf[v.rs1];
      eb = mrf[v.rs2];
      wb_lat = v.op == LDI ? 2 : 4;
      #1 chk("ready_at_issue", cmd_ready_o, 1);
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
        @(negedge clk_i);
        if (res_valid_o) lat = c;
        else begin
          chk("ready_busy", cmd_ready_o, 0);
          if (c < wb_lat - 1) begin
            chk("alu_a", alu_a_o, ea);
            chk("alu_b", alu_b_o, eb);
            chk("alu_op", alu_op_o, v.op);
          end else begin
            chk("alu_op_idle_wb", alu_op_o, 0);
            chk("alu_a_idle_wb", alu_a_o, 0);
            chk("dbg_old_in_wb", dbg_data_o, mrf[v.rd]);
          end
        end
      end
      chk("latency", lat, wb_lat);
      chk("res_rd", res_rd_o, v.rd);
      chk("res_data", res_data_o, v.data);
      chk("res_carry", res_carry_o, v.carry);
      chk("dbg_new", dbg_data_o, v.data);
      mrf[v.rd] = v.data;
    end
    cmd_valid_i = 0;
    chk("accept_count", n_acc, N);
    @(negedge clk_i);
    chk("res_count", n_res, N);
    chk("res_valid_single", res_valid_o, 0);
    cmd_op_i = ADD;
    cmd_rd_i = 3;
    cmd_rs1_i = 1;
    cmd_rs2_i = 2;
    cmd_valid_i = 1;
    @(negedge clk_i);
    cmd_valid_i = 0;
    @(negedge clk_i);
    chk("exec_before_reset", alu_op_o, ADD);
    rst_i = 1;
    @(negedge clk_i);
    chk("abort_res_valid", res_valid_o, 0);
    chk("ready_in_reset", cmd_ready_o, 0);
    chk("abort_alu_op", alu_op_o, 0);
    chk("abort_res_data", res_data_o, 0);
    rst_i = 0;
    @(negedge clk_i);
    chk("ready_after_abort", cmd_ready_o, 1);
    repeat (4) @(negedge clk_i);
    chk("abort_no_result", n_res, N);
    chk_regs_zero("abort_regfile");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
